// File: rtl/enemy_bullet_gen_if.sv
// Enemy-bullet link: enemy position/strobes in, bullet position and status out.
interface enemy_bullet_gen_if;
    logic       tick;
    logic [9:0] e_x;
    logic [9:0] e_y;
    logic       enemy_en;
    logic       hit;
    logic [9:0] eb_x;
    logic [9:0] eb_y;
    logic       enemy_bullet_en;
    logic [7:0] shot_count;

    modport master (
        input  tick, e_x, e_y, enemy_en, hit,
        output eb_x, eb_y, enemy_bullet_en, shot_count
    );

    modport slave (
        output tick, e_x, e_y, enemy_en, hit,
        input  eb_x, eb_y, enemy_bullet_en, shot_count
    );
endinterface

// File: rtl/enemy_bullet_gen.sv
// Spawns a single enemy bullet from the enemy origin and moves it down-screen
// until the player judge reports a hit or it leaves the playfield.
module enemy_bullet_gen #(
    parameter int unsigned SPAWN_DX = 20,
    parameter int unsigned SPAWN_DY = 40,
    parameter int unsigned STEP     = 4,
    parameter int unsigned Y_LIMIT  = 960,
    parameter int unsigned RELOAD   = 60
) (
    input  logic                clk,
    input  logic                rst,
    enemy_bullet_gen_if.master  bus
);

    localparam logic [9:0]  DX      = 10'(SPAWN_DX);
    localparam logic [10:0] DY      = 11'(SPAWN_DY);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [10:0] LIMIT11 = 11'(Y_LIMIT);
    localparam logic [7:0]  RLD_M1  = 8'(RELOAD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RELOAD = 2'd1,
        S_FLY    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [7:0]  shot_q, shot_d;

    // 11-bit sums so the limit compare never sees a wrapped coordinate
    logic [10:0] spawn_y;
    logic [10:0] next_y;
    logic        retire;

    assign spawn_y = {1'b0, bus.e_y} + DY;
    assign next_y  = {1'b0, y_q} + STEP11;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            shot_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            shot_q  <= shot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        shot_d  = shot_q;
        retire  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.enemy_en) begin
                    cnt_d   = RLD_M1;
                    state_d = S_RELOAD;
                end
            end
            S_RELOAD: begin
                if (!bus.enemy_en) begin
                    state_d = S_IDLE;
                end else if (bus.tick) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (spawn_y < LIMIT11) begin
                        x_d     = bus.e_x + DX;
                        y_d     = spawn_y[9:0];
                        shot_d  = shot_q + 8'd1;
                        state_d = S_FLY;
                    end else begin
                        cnt_d = RLD_M1;
                    end
                end
            end
            S_FLY: begin
                // a hit coinciding with an out-of-bounds tick is one retire
                retire = bus.hit || (bus.tick && (next_y >= LIMIT11));
                if (retire) begin
                    cnt_d   = RLD_M1;
                    state_d = bus.enemy_en ? S_RELOAD : S_IDLE;
                end else if (bus.tick) begin
                    y_d = next_y[9:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.eb_x            = x_q;
    assign bus.eb_y            = y_q;
    assign bus.enemy_bullet_en = (state_q == S_FLY);
    assign bus.shot_count      = shot_q;

endmodule

// File: tb/tb_enemy_bullet_gen.sv
// Directed bench for enemy_bullet_gen with RELOAD=3: spawn, flight, exits, hits, disable, reset.
module tb_enemy_bullet_gen;

    logic clk;
    logic rst;
    int unsigned n_assert;
    int unsigned n_fail;

    enemy_bullet_gen_if bif ();

    enemy_bullet_gen #(
        .SPAWN_DX (20),
        .SPAWN_DY (40),
        .STEP     (4),
        .Y_LIMIT  (960),
        .RELOAD   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one-clk tick strobe, followed by gap-1 idle cycles
    task automatic tick_n(input int unsigned n, input int unsigned gap);
        for (int unsigned i = 0; i < n; i++) begin
            bif.tick = 1'b1;
            step();
            bif.tick = 1'b0;
            for (int unsigned j = 1; j < gap; j++) step();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst          = 1'b0;
        bif.tick     = 1'b0;
        bif.hit      = 1'b0;
        bif.enemy_en = 1'b1;
        bif.e_x      = 10'd100;
        bif.e_y      = 10'd200;
        step();
        step();
        chk("rst_en",   32'(bif.enemy_bullet_en), 32'd0);
        chk("rst_x",    32'(bif.eb_x),            32'd0);
        chk("rst_y",    32'(bif.eb_y),            32'd0);
        chk("rst_shot", 32'(bif.shot_count),      32'd0);

        // release reset; first edge moves IDLE -> RELOAD
        rst = 1'b1;
        step();
        tick_n(2, 4);
        chk("pre_spawn_en", 32'(bif.enemy_bullet_en), 32'd0);
        bif.tick = 1'b1;
        step();
        bif.tick = 1'b0;
        chk("spawn_en",   32'(bif.enemy_bullet_en), 32'd1);
        chk("spawn_x",    32'(bif.eb_x),            32'd120);
        chk("spawn_y",    32'(bif.eb_y),            32'd240);
        chk("spawn_shot", 32'(bif.shot_count),      32'd1);
        step();
        step();
        step();

        // flight: 10 ticks, enemy moves mid-way
        tick_n(5, 4);
        bif.e_x = 10'd300;
        tick_n(5, 4);
        chk("fly_y", 32'(bif.eb_y), 32'd280);
        chk("fly_x", 32'(bif.eb_x), 32'd120);
        chk("fly_en", 32'(bif.enemy_bullet_en), 32'd1);

        // single-cycle hit
        bif.hit = 1'b1;
        step();
        bif.hit = 1'b0;
        chk("hit_en",   32'(bif.enemy_bullet_en), 32'd0);
        chk("hit_y",    32'(bif.eb_y),            32'd280);
        chk("hit_shot", 32'(bif.shot_count),      32'd1);

        // hit while reloading is ignored
        bif.hit = 1'b1;
        step();
        bif.hit = 1'b0;
        chk("hit_reload_en", 32'(bif.enemy_bullet_en), 32'd0);

        // respawn near the bottom: 912+40 = 952
        bif.e_y = 10'd912;
        tick_n(3, 2);
        chk("spawn2_en",   32'(bif.enemy_bullet_en), 32'd1);
        chk("spawn2_x",    32'(bif.eb_x),            32'd320);
        chk("spawn2_y",    32'(bif.eb_y),            32'd952);
        chk("spawn2_shot", 32'(bif.shot_count),      32'd2);
        tick_n(1, 2);
        chk("move956_y", 32'(bif.eb_y), 32'd956);

        // hit together with out-of-bounds tick: one retire
        bif.hit  = 1'b1;
        bif.tick = 1'b1;
        step();
        bif.hit  = 1'b0;
        bif.tick = 1'b0;
        chk("hit_oob_en",   32'(bif.enemy_bullet_en), 32'd0);
        chk("hit_oob_y",    32'(bif.eb_y),            32'd956);
        chk("hit_oob_shot", 32'(bif.shot_count),      32'd2);

        // next spawn needs RELOAD ticks
        tick_n(2, 2);
        chk("reload_wait_en", 32'(bif.enemy_bullet_en), 32'd0);
        tick_n(1, 2);
        chk("spawn3_en",   32'(bif.enemy_bullet_en), 32'd1);
        chk("spawn3_shot", 32'(bif.shot_count),      32'd3);

        // bottom exit: 952 -> 956 -> retire (956+4 >= 960)
        tick_n(1, 2);
        chk("exit_pre_en", 32'(bif.enemy_bullet_en), 32'd1);
        tick_n(1, 2);
        chk("exit_en", 32'(bif.enemy_bullet_en), 32'd0);
        chk("exit_y",  32'(bif.eb_y),            32'd956);

        // disable during flight: bullet 240 flies out in 180 ticks
        bif.e_y = 10'd200;
        tick_n(3, 2);
        chk("spawn4_shot", 32'(bif.shot_count), 32'd4);
        bif.enemy_en = 1'b0;
        tick_n(179, 2);
        chk("dis_fly_en", 32'(bif.enemy_bullet_en), 32'd1);
        chk("dis_fly_y",  32'(bif.eb_y),            32'd956);
        tick_n(1, 2);
        chk("dis_exit_en", 32'(bif.enemy_bullet_en), 32'd0);
        tick_n(5, 2);
        chk("dis_idle_en",   32'(bif.enemy_bullet_en), 32'd0);
        chk("dis_idle_shot", 32'(bif.shot_count),      32'd4);

        // disable during reload
        bif.enemy_en = 1'b1;
        step();
        tick_n(1, 2);
        bif.enemy_en = 1'b0;
        step();
        tick_n(5, 2);
        chk("dis_reload_en",   32'(bif.enemy_bullet_en), 32'd0);
        chk("dis_reload_shot", 32'(bif.shot_count),      32'd4);

        // re-enable: fresh reload from IDLE
        bif.enemy_en = 1'b1;
        step();
        tick_n(2, 2);
        chk("reen_wait_en", 32'(bif.enemy_bullet_en), 32'd0);
        tick_n(1, 2);
        chk("reen_en",   32'(bif.enemy_bullet_en), 32'd1);
        chk("reen_y",    32'(bif.eb_y),            32'd240);
        chk("reen_shot", 32'(bif.shot_count),      32'd5);

        // async reset between clock edges
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_en",   32'(bif.enemy_bullet_en), 32'd0);
        chk("async_x",    32'(bif.eb_x),            32'd0);
        chk("async_y",    32'(bif.eb_y),            32'd0);
        chk("async_shot", 32'(bif.shot_count),      32'd0);

        // spawn point below the limit: 930+40 = 970 never spawns
        bif.e_y = 10'd930;
        step();
        rst = 1'b1;
        step();
        tick_n(10, 2);
        chk("nospawn_en",   32'(bif.enemy_bullet_en), 32'd0);
        chk("nospawn_shot", 32'(bif.shot_count),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
